obuf_tag_ring: RTL

Parametrised output-buffer tag manager for N-deep buffering of the OBUF between DDR load, PE-array compute and DDR store. It accepts tile requests from the instruction decoder through an internal request FIFO, allocates tags round-robin, and tracks each tag through FREE → LDMEM → COMPUTE → STMEM. It supports multiple compute passes per tag (reuse) and explicit block-done flush markers. It is the generalised successor of the two-tag OBUF tag synchroniser and sits between the decoder and the ldmem/compute/stmem controllers.

---
 rtl/obuf_tag_pkg.sv | 21 ++
 rtl/obuf_tag_ring_fifo.sv | 49 ++++
 rtl/obuf_tag_ring.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/obuf_tag_pkg.sv
// Shared encodings for the OBUF tag ring: per-tag lifecycle states and
// the layout of one request-FIFO entry.
package obuf_tag_pkg;

    typedef enum logic [1:0] {
        TAG_FREE    = 2'd0,
        TAG_LDMEM   = 2'd1,
        TAG_COMPUTE = 2'd2,
        TAG_STMEM   = 2'd3
    } tag_state_e;

    typedef struct packed {
        logic flush;
        logic reuse;
        logic bias_sw;
        logic ddr_sw;
    } req_entry_t;

    localparam int REQ_ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/obuf_tag_ring_fifo.sv
// Synchronous FIFO with a combinational head read; an entry written at one
// edge is visible on rd_data right after that edge.
module obuf_tag_ring_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (ADDR_WIDTH+1)'(do_wr) - (ADDR_WIDTH+1)'(do_rd);
        end
    end

    // Storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/obuf_tag_ring.sv
// N-deep OBUF tag manager: buffers decoder requests, hands out tags
// round-robin and walks each tag through LDMEM -> COMPUTE -> STMEM -> FREE.
module obuf_tag_ring
    import obuf_tag_pkg::*;
#(
    parameter int NUM_TAGS       = 2,
    parameter int TAG_W          = $clog2(NUM_TAGS),
    parameter int REQ_FIFO_DEPTH = 16,
    parameter int MAX_PENDING    = 15,
    parameter int CNT_W          = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_flush,
    input  logic             req_reuse,
    input  logic             req_bias_sw,
    input  logic             req_ddr_sw,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    output logic [TAG_W-1:0] ldmem_tag,
    output logic             ldmem_tag_ready,
    input  logic             ldmem_tag_done,
    output logic [TAG_W-1:0] compute_tag,
    output logic             compute_tag_ready,
    output logic             compute_bias_sw,
    input  logic             compute_tag_done,
    output logic [TAG_W-1:0] stmem_tag,
    output logic             stmem_tag_ready,
    output logic             stmem_ddr_sw,
    input  logic             stmem_tag_done,
    output logic             idle,
    output logic             err_done
);

    localparam int FIFO_AW = $clog2(REQ_FIFO_DEPTH);

    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(NUM_TAGS - 1)) ? '0 : p + 1'b1;
    endfunction

    tag_state_e       tag_state   [NUM_TAGS];
    logic [CNT_W-1:0] tag_pending [NUM_TAGS];
    logic             tag_flushed [NUM_TAGS];
    logic             tag_bias    [NUM_TAGS];
    logic             tag_ddr     [NUM_TAGS];

    logic [TAG_W-1:0] alloc_ptr, ld_ptr, cmp_ptr, st_ptr, open_tag;
    logic             open_valid;

    req_entry_t wr_entry, head;
    logic       fifo_full, fifo_empty, pop;

    logic ld_ready, cmp_ready, st_ready;
    logic ld_fire, cmp_fire, st_fire, cmp_retire;
    logic alloc_new, close_open, all_free;
    logic [NUM_TAGS-1:0] new_alloc, inc, dec, set_flush, ld_adv, st_adv, retire;

    assign wr_entry  = '{flush: req_flush, reuse: req_reuse, bias_sw: req_bias_sw, ddr_sw: req_ddr_sw};
    assign req_ready = !fifo_full;

    obuf_tag_ring_fifo #(
        .DATA_WIDTH (REQ_ENTRY_W),
        .ADDR_WIDTH (FIFO_AW)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (req_valid),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Stage-facing handshakes decode straight from the registered tag state.
    assign ld_ready   = (tag_state[ld_ptr] == TAG_LDMEM);
    assign cmp_ready  = (tag_state[cmp_ptr] == TAG_COMPUTE) && (tag_pending[cmp_ptr] != '0);
    assign st_ready   = (tag_state[st_ptr] == TAG_STMEM);
    assign ld_fire    = ldmem_tag_done && ld_ready;
    assign cmp_fire   = compute_tag_done && cmp_ready;
    assign st_fire    = stmem_tag_done && st_ready;
    assign cmp_retire = (tag_state[cmp_ptr] == TAG_COMPUTE) && (tag_pending[cmp_ptr] == '0)
                        && tag_flushed[cmp_ptr];

    assign ldmem_tag         = ld_ptr;
    assign ldmem_tag_ready   = ld_ready;
    assign compute_tag       = cmp_ptr;
    assign compute_tag_ready = cmp_ready;
    assign compute_bias_sw   = tag_bias[cmp_ptr];
    assign stmem_tag         = st_ptr;
    assign stmem_tag_ready   = st_ready;
    assign stmem_ddr_sw      = tag_ddr[st_ptr];
    assign idle              = fifo_empty && all_free;

    always_comb begin
        all_free = 1'b1;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (tag_state[i] != TAG_FREE) all_free = 1'b0;
        end
    end

    // Head-of-queue decision: at most one entry consumed per cycle.
    always_comb begin
        pop         = 1'b0;
        alloc_valid = 1'b0;
        alloc_tag   = '0;
        alloc_new   = 1'b0;
        close_open  = 1'b0;
        new_alloc   = '0;
        inc         = '0;
        set_flush   = '0;
        if (!fifo_empty) begin
            if (head.flush) begin
                pop        = 1'b1;
                close_open = open_valid;
                if (open_valid) set_flush[open_tag] = 1'b1;
            end else if (head.reuse && open_valid) begin
                if (tag_pending[open_tag] < CNT_W'(MAX_PENDING)) begin
                    pop           = 1'b1;
                    alloc_valid   = 1'b1;
                    alloc_tag     = open_tag;
                    inc[open_tag] = 1'b1;
                end
            end else if (tag_state[alloc_ptr] == TAG_FREE) begin
                pop                  = 1'b1;
                alloc_valid          = 1'b1;
                alloc_tag            = alloc_ptr;
                alloc_new            = 1'b1;
                new_alloc[alloc_ptr] = 1'b1;
                if (open_valid) set_flush[open_tag] = 1'b1;
            end
        end
    end

    always_comb begin
        dec    = '0;
        ld_adv = '0;
        st_adv = '0;
        retire = '0;
        if (cmp_fire)   dec[cmp_ptr]    = 1'b1;
        if (ld_fire)    ld_adv[ld_ptr]  = 1'b1;
        if (st_fire)    st_adv[st_ptr]  = 1'b1;
        if (cmp_retire) retire[cmp_ptr] = 1'b1;
    end

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
        always_ff @(posedge clk) begin
            if (reset) begin
                tag_state[g]   <= TAG_FREE;
                tag_pending[g] <= '0;
                tag_flushed[g] <= 1'b0;
                tag_bias[g]    <= 1'b0;
                tag_ddr[g]     <= 1'b0;
            end else if (new_alloc[g]) begin
                tag_state[g]   <= TAG_LDMEM;
                tag_pending[g] <= CNT_W'(1);
                tag_flushed[g] <= 1'b0;
                tag_bias[g]    <= head.bias_sw;
                tag_ddr[g]     <= head.ddr_sw;
            end else begin
                // A reuse and a finished pass in the same cycle cancel out.
                tag_pending[g] <= tag_pending[g] + CNT_W'(inc[g]) - CNT_W'(dec[g]);
                if (set_flush[g]) tag_flushed[g] <= 1'b1;
                case (tag_state[g])
                    TAG_LDMEM:   if (ld_adv[g]) tag_state[g] <= TAG_COMPUTE;
                    TAG_COMPUTE: if (retire[g]) tag_state[g] <= TAG_STMEM;
                    TAG_STMEM:   if (st_adv[g]) tag_state[g] <= TAG_FREE;
                    default:     tag_state[g] <= tag_state[g];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr  <= '0;
            ld_ptr     <= '0;
            cmp_ptr    <= '0;
            st_ptr     <= '0;
            open_tag   <= '0;
            open_valid <= 1'b0;
            err_done   <= 1'b0;
        end else begin
            if (alloc_new) begin
                alloc_ptr  <= wrap_inc(alloc_ptr);
                open_tag   <= alloc_ptr;
                open_valid <= 1'b1;
            end else if (close_open) begin
                open_valid <= 1'b0;
            end
            if (ld_fire)    ld_ptr  <= wrap_inc(ld_ptr);
            if (cmp_retire) cmp_ptr <= wrap_inc(cmp_ptr);
            if (st_fire)    st_ptr  <= wrap_inc(st_ptr);
            err_done <= (ldmem_tag_done && !ld_ready) || (compute_tag_done && !cmp_ready)
                        || (stmem_tag_done && !st_ready);
        end
    end

endmodule
